// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the zero-crossing frequency meter.
package freq_meter_pkg;

   typedef enum logic {
      LOW  = 1'b0,
      HIGH = 1'b1
   } schmitt_state_t;

   // Increment that sticks at 2^width-1; callers cast the result to their own width.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
      logic [31:0] max_v;
      max_v = (32'd1 << width) - 32'd1;
      return (value >= max_v) ? max_v : value + 32'd1;
   endfunction

endpackage

// File: rtl/freq_meter_schmitt_trigger.sv
// Hysteretic zero-crossing detector; rise is a combinational strobe on the accepting edge.
// state | meaning
// LOW   | last qualified excursion was at or below -HYST (or reset)
// HIGH  | last qualified excursion was at or above +HYST
module schmitt_trigger
   import freq_meter_pkg::*;
#(
   parameter int DW   = 10,
   parameter int HYST = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic signed [DW-1:0] in,
   output schmitt_state_t       state,
   output logic                 rise
);

   localparam logic signed [DW-1:0] HI_TH = DW'(HYST);
   localparam logic signed [DW-1:0] LO_TH = -HI_TH;

   schmitt_state_t state_q, state_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= LOW;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      rise    = 1'b0;
      if (en) begin
         case (state_q)
            LOW: begin
               if (in >= HI_TH) begin
                  state_d = HIGH;
                  rise    = 1'b1;
               end
            end
            HIGH: begin
               if (in <= LO_TH) state_d = LOW;
            end
            default: state_d = LOW;
         endcase
      end
   end

   assign state = state_q;

endmodule

// File: rtl/freq_meter.sv
// Gated rising-crossing counter with period measurement and saturation flag.
// Define FREQ_METER_PEAK_EN to add the per-gate peak |in| output.
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int DW   = 10,
   parameter int HYST = 16,
   parameter int GATE = 3000,
   parameter int CW   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic signed [DW-1:0] in,
   output logic [CW-1:0]        count,
   output logic [CW-1:0]        period,
   output logic                 valid,
`ifdef FREQ_METER_PEAK_EN
   output logic [DW-2:0]        peak,
`endif
   output logic                 ovf
);

   localparam int              GW        = $clog2(GATE);
   localparam logic [GW-1:0]   GATE_LAST = GW'(GATE - 1);
   localparam logic [CW-1:0]   CW_MAX    = '1;

   schmitt_state_t schmitt_state;
   logic           rise, rise_evt, gate_end, cnt_sat, per_sat;
   logic [CW-1:0]  run_inc, per_inc;

   logic [GW-1:0]  gate_cnt_q, gate_cnt_d;
   logic [CW-1:0]  run_cnt_q, run_cnt_d;
   logic [CW-1:0]  per_cnt_q, per_cnt_d;
   logic           run_ovf_q, run_ovf_d;
   logic           have_prev_q, have_prev_d;
   logic [CW-1:0]  count_q, count_d;
   logic [CW-1:0]  period_q, period_d;
   logic           valid_q, valid_d;
   logic           ovf_q, ovf_d;

   schmitt_trigger #(.DW(DW), .HYST(HYST)) u_schmitt (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .in    (in),
      .state (schmitt_state),
      .rise  (rise)
   );

   assign rise_evt = rise && (schmitt_state == LOW);
   assign gate_end = en && (gate_cnt_q == GATE_LAST);
   assign run_inc  = rise_evt ? CW'(sat_inc(32'(run_cnt_q), CW)) : run_cnt_q;
   assign per_inc  = CW'(sat_inc(32'(per_cnt_q), CW));
   assign cnt_sat  = rise_evt && (run_cnt_q == CW_MAX);
   assign per_sat  = en && (per_cnt_q == CW_MAX);

   always_comb begin
      gate_cnt_d  = gate_cnt_q;
      run_cnt_d   = run_cnt_q;
      per_cnt_d   = per_cnt_q;
      run_ovf_d   = run_ovf_q;
      have_prev_d = have_prev_q;
      count_d     = count_q;
      period_d    = period_q;
      ovf_d       = ovf_q;
      valid_d     = 1'b0;
      if (en) begin
         per_cnt_d = per_inc;
         if (rise_evt) begin
            per_cnt_d   = '0;
            have_prev_d = 1'b1;
            if (have_prev_q) period_d = per_inc;
         end
         // The closing edge's event and saturation belong to the result being latched.
         if (gate_end) begin
            count_d    = run_inc;
            ovf_d      = run_ovf_q | cnt_sat | per_sat;
            valid_d    = 1'b1;
            gate_cnt_d = '0;
            run_cnt_d  = '0;
            run_ovf_d  = 1'b0;
         end else begin
            gate_cnt_d = gate_cnt_q + GW'(1);
            run_cnt_d  = run_inc;
            run_ovf_d  = run_ovf_q | cnt_sat | per_sat;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gate_cnt_q  <= '0;
         run_cnt_q   <= '0;
         per_cnt_q   <= '0;
         run_ovf_q   <= 1'b0;
         have_prev_q <= 1'b0;
         count_q     <= '0;
         period_q    <= '0;
         valid_q     <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         gate_cnt_q  <= gate_cnt_d;
         run_cnt_q   <= run_cnt_d;
         per_cnt_q   <= per_cnt_d;
         run_ovf_q   <= run_ovf_d;
         have_prev_q <= have_prev_d;
         count_q     <= count_d;
         period_q    <= period_d;
         valid_q     <= valid_d;
         ovf_q       <= ovf_d;
      end
   end

   assign count  = count_q;
   assign period = period_q;
   assign valid  = valid_q;
   assign ovf    = ovf_q;

`ifdef FREQ_METER_PEAK_EN
   logic [DW-1:0] neg_in;
   logic [DW-2:0] mag;
   logic [DW-2:0] peak_run_q, peak_run_d;
   logic [DW-2:0] peak_q, peak_d;

   // Most negative sample has no positive twin; clamp it to the largest magnitude.
   always_comb begin
      neg_in = -in;
      if (!in[DW-1])          mag = in[DW-2:0];
      else if (neg_in[DW-1])  mag = '1;
      else                    mag = neg_in[DW-2:0];
   end

   always_comb begin
      peak_run_d = peak_run_q;
      peak_d     = peak_q;
      if (en) begin
         if (gate_end) begin
            peak_d     = (mag > peak_run_q) ? mag : peak_run_q;
            peak_run_d = '0;
         end else if (mag > peak_run_q) begin
            peak_run_d = mag;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         peak_run_q <= '0;
         peak_q     <= '0;
      end else begin
         peak_run_q <= peak_run_d;
         peak_q     <= peak_d;
      end
   end

   assign peak = peak_q;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Randomized bench for freq_meter: a behavioural model queues each expected gate result,
// and per-DUT monitors check them when valid pulses (CW=16 and CW=4 instances in parallel).
module tb_freq_meter;

   localparam int DW   = 10;
   localparam int HYST = 16;
   localparam int GATE = 3000;

   typedef struct {
      int     rises;
      int     gap;
      int     max_since;
      int     peak;
      longint cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en  = 1'b0;
   logic signed [DW-1:0] in_s = '0;

   logic [15:0] count16, period16;
   logic        valid16, ovf16;
   logic [3:0]  count4, period4;
   logic        valid4, ovf4;
`ifdef FREQ_METER_PEAK_EN
   logic [DW-2:0] peak16, peak4;
`endif

   int     checks = 0;
   int     errors = 0;
   longint cyc    = 0;
   exp_t   q16[$];
   exp_t   q4[$];

   bit m_high, m_have_prev;
   int m_gate_n, m_rises, m_since, m_max_since, m_gap, m_peak;

   freq_meter #(.DW(DW), .HYST(HYST), .GATE(GATE), .CW(16)) u_dut16 (
      .clk(clk), .rst(rst), .en(en), .in(in_s),
      .count(count16), .period(period16), .valid(valid16),
`ifdef FREQ_METER_PEAK_EN
      .peak(peak16),
`endif
      .ovf(ovf16)
   );

   freq_meter #(.DW(DW), .HYST(HYST), .GATE(GATE), .CW(4)) u_dut4 (
      .clk(clk), .rst(rst), .en(en), .in(in_s),
      .count(count4), .period(period4), .valid(valid4),
`ifdef FREQ_METER_PEAK_EN
      .peak(peak4),
`endif
      .ovf(ovf4)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic longint clampw(input longint v, input longint maxw);
      return (v > maxw) ? maxw : v;
   endfunction

   task automatic model_reset();
      m_high = 0; m_have_prev = 0;
      m_gate_n = 0; m_rises = 0; m_since = 0; m_max_since = 0; m_gap = 0; m_peak = 0;
   endtask

   // One accepted sample: unbounded integers here, width saturation applied at compare time.
   task automatic model_edge(input int x);
      bit   r;
      int   a;
      exp_t e;
      r = 0;
      if (!m_high && x >= HYST) begin
         m_high = 1; r = 1;
      end else if (m_high && x <= -HYST) begin
         m_high = 0;
      end
      if (m_since > m_max_since) m_max_since = m_since;
      a = (x < 0) ? -x : x;
      if (a > (1 << (DW - 1)) - 1) a = (1 << (DW - 1)) - 1;
      if (a > m_peak) m_peak = a;
      if (r) begin
         m_rises++;
         if (m_have_prev) m_gap = m_since + 1;
         m_have_prev = 1;
         m_since = 0;
      end else begin
         m_since++;
      end
      m_gate_n++;
      if (m_gate_n == GATE) begin
         e.rises = m_rises; e.gap = m_gap; e.max_since = m_max_since;
         e.peak = m_peak; e.cyc = cyc + 1;
         q16.push_back(e);
         q4.push_back(e);
         m_gate_n = 0; m_rises = 0; m_max_since = 0; m_peak = 0;
      end
   endtask

   task automatic step(input bit en_v, input int x);
      en   = en_v;
      in_s = DW'(x);
      if (en_v && rst) model_edge(x);
      @(posedge clk);
      #1;
   endtask

   function automatic int sq(input int n);
      return (((n / 15) % 2) != 0) ? -500 : 500;
   endfunction

   task automatic check_result(input string tag, input longint maxw, input longint c,
                               input longint p, input longint o, input exp_t e);
      chk({tag, "_count"}, c, clampw(e.rises, maxw));
      chk({tag, "_period"}, p, clampw(e.gap, maxw));
      chk({tag, "_ovf"}, o, ((e.rises > maxw) || (e.max_since >= maxw)) ? 1 : 0);
      chk({tag, "_valid_cycle"}, cyc, e.cyc);
   endtask

   always @(negedge clk) begin : mon16
      exp_t e;
      if (valid16) begin
         if (q16.size() == 0) begin
            checks++; errors++;
            $display("FAIL valid16_unexpected: got valid at cycle %0d, expected none", cyc);
         end else begin
            e = q16.pop_front();
            check_result("cw16", 65535, count16, period16, ovf16, e);
`ifdef FREQ_METER_PEAK_EN
            chk("cw16_peak", peak16, e.peak);
`endif
         end
      end
   end

   always @(negedge clk) begin : mon4
      exp_t e;
      if (valid4) begin
         if (q4.size() == 0) begin
            checks++; errors++;
            $display("FAIL valid4_unexpected: got valid at cycle %0d, expected none", cyc);
         end else begin
            e = q4.pop_front();
            check_result("cw4", 15, count4, period4, ovf4, e);
`ifdef FREQ_METER_PEAK_EN
            chk("cw4_peak", peak4, e.peak);
`endif
         end
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_count16"}, count16, 0);
      chk({tag, "_period16"}, period16, 0);
      chk({tag, "_valid16"}, valid16, 0);
      chk({tag, "_ovf16"}, ovf16, 0);
      chk({tag, "_count4"}, count4, 0);
      chk({tag, "_period4"}, period4, 0);
      chk({tag, "_ovf4"}, ovf4, 0);
`ifdef FREQ_METER_PEAK_EN
      chk({tag, "_peak16"}, peak16, 0);
`endif
   endtask

   initial begin
      int sn, ph, acc;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b1;

      // Clean square wave, random starting phase.
      sn = $urandom_range(0, 29);
      for (int n = 0; n < 3 * GATE; n++) begin step(1, sq(sn)); sn++; end

      // Square wave with sub-hysteresis noise.
      for (int n = 0; n < 2 * GATE; n++) begin
         step(1, sq(sn) + int'($urandom_range(0, 20)) - 10); sn++;
      end

      // Sine, amplitude 460, 100 samples per cycle.
      ph = $urandom_range(0, 99);
      for (int n = 0; n < 2 * GATE; n++)
         step(1, int'(460.0 * $sin(6.283185307179586 * real'(n + ph) / 100.0)));

      // Strict en toggling with junk on the idle cycles, then random en.
      for (int n = 0; n < 2 * GATE; n++) begin
         step(1, sq(sn)); sn++;
         step(0, int'($urandom_range(0, 1023)) - 512);
      end
      acc = 0;
      while (acc < GATE) begin
         if ($urandom_range(0, 1) != 0) begin step(1, sq(sn)); sn++; acc++; end
         else step(0, int'($urandom_range(0, 1023)) - 512);
      end

      // Input held inside the hysteresis band.
      for (int n = 0; n < GATE; n++) step(1, int'($urandom_range(0, 20)) - 10);

      // Square again, then asynchronous reset halfway through a gate.
      for (int n = 0; n < 2 * GATE; n++) begin step(1, sq(sn)); sn++; end
      while (m_gate_n != GATE / 2) begin step(1, sq(sn)); sn++; end
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check_zero("async_rst");
      @(posedge clk); #1;
      step(1, 500);
      step(1, -500);
      rst = 1'b1;
      sn = 0;
      for (int n = 0; n < 2 * GATE; n++) begin step(1, sq(sn)); sn++; end

      repeat (5) step(0, 0);
      chk("q16_drained", q16.size(), 0);
      chk("q4_drained", q4.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of a signed sampled waveform, such as the output of the DDS or the IIR, using hysteretic zero-crossing detection.
- Counts rising crossings over a fixed gate of GATE input samples and reports that count.
- Also reports the sample count between the two most recent rising crossings, as a period.
- Sits downstream of signal sources to close the loop on generated frequencies: frequency = count × fs / GATE.

Parameters:
- DW, 10, input sample width (signed).
- HYST, 16, hysteresis threshold magnitude; must satisfy 0 < HYST < 2^(DW-1).
- GATE, 3000, gate length in accepted samples; must be ≥ 2.
- CW, 16, width of the crossing count and period outputs.

Ports:
- clk  in  1  clock; all registers rise-edge triggered.
- rst  in  1  reset; asynchronous, active-low.
- en  in  1  sample enable; `in` is accepted on an edge where en=1.
- in  in  DW  signed input sample.
- count  out  CW  rising crossings counted in the last completed gate.
- period  out  CW  samples between the last two rising crossings.
- valid  out  1  one-cycle pulse: count is newly updated.
- ovf  out  1  count or period saturated in the current result; sticky per result.

Behaviour:
- Reset (rst=0, asynchronous) clears all registers:
  - schmitt state=LOW, gate counter=0, running count=0, period counter=0, have_prev=0;
  - count=0, period=0, valid=0, ovf=0.
- On release of rst, operation begins at the next en edge.
- Schmitt trigger, two states, evaluated combinationally on `in` at each en edge:
  - LOW → HIGH when in ≥ +HYST; this is a rising event.
  - HIGH → LOW when in ≤ −HYST.
  - Values inside (−HYST, +HYST) hold the state.
  - Falling transitions produce no event.
- Gate:
  - The gate counter increments on each en edge.
  - At the en edge where gate counter = GATE−1:
    - count ← running count + (rising event this edge), saturated at 2^CW−1;
    - gate counter ← 0; running count ← 0;
    - valid=1 for exactly the following cycle.
  - Otherwise running count += event, saturating.
- Period:
  - The period counter increments on each en edge, saturating at 2^CW−1.
  - On a rising event with have_prev=1: period ← period counter + 1, and the period counter clears to 0.
  - On the first rising event after reset: have_prev ← 1, period counter clears, period is unchanged.
- Latency: a rising event on edge t is reflected in period at t+1 (registered output).
- ovf:
  - Set when the running count saturates or the period counter saturates.
  - Latched into the result alongside count.
  - Cleared at the next gate start unless the saturation persists.
- en=0: every register holds its value; valid stays 0; the gate does not advance.
- Simultaneous gate end and rising event: the event is included in the closing count and is not in the next gate's count.
- Reset mid-gate: the partial count is discarded; no valid pulse is produced.

Optional Feature:
- Macro FREQ_METER_PEAK_EN.
- When defined:
  - Adds output `peak`, DW−1 bits unsigned: the maximum |in| seen over the gate.
  - Latched together with count on the gate-end edge, including that edge's sample.
  - |−2^(DW−1)| saturates to 2^(DW−1)−1.
  - Resets to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package freq_meter_pkg:
  - enum schmitt_state_t {LOW, HIGH};
  - function sat_inc(value, width).
- Sub-module schmitt_trigger (clk, rst, en, in, state, rise), parameterised by DW and HYST; the top instantiates one.
- Gate, count, period and peak logic live in freq_meter.

Test Plan:
1. Square wave ±500, toggling every 15 accepted samples (period 30), en=1, GATE=3000 → after the first full gate: count=100, period=30, valid pulses exactly once per 3000 cycles, ovf=0.
2. DDS sine, amplitude 460, FCW=2^32·1e6/100e6 (1 MHz at fs=100 MHz), GATE=3000 → count=30 (±1), period alternating 100 (±1).
3. Noise of ±10 around 0 (|x| < HYST) superimposed on the square wave from case 1 → count stays 100; an input held at ±10 alone gives count=0 and period unchanged.
4. en toggled 1/0 every cycle with the square wave from case 1 → identical count and period values; valid spacing doubles to 6000 cycles.
5. CW=4, square period 30, GATE=3000 → count=15 with ovf=1; period saturates at 15 with ovf=1.
6. rst asserted at sample 1500 of a gate → all outputs 0 immediately (asynchronously); the next valid arrives exactly GATE en edges after release, with count=100; with FREQ_METER_PEAK_EN, peak=500.
